// File: rtl/buffer_xbar_pkg.sv
// Shared field widths and word-layout helpers for the packet-buffer crossbar.
package bpf_xbar_pkg;

  localparam int unsigned ENABLE_BIT = 1;
  localparam int unsigned VLD_BIT    = 1;
  localparam int unsigned RESET_SIG  = 1;

  // {reset_sig, rd_en} sit below the snooper fields in a buffer input word
  localparam int unsigned CTRL_PAD_W = RESET_SIG + ENABLE_BIT;

  function automatic int unsigned bin_w(input int unsigned addr_w, input int unsigned data_w,
                                        input int unsigned inc_w);
    return addr_w + data_w + ENABLE_BIT + inc_w + CTRL_PAD_W;
  endfunction

  function automatic int unsigned bout_w(input int unsigned data_w, input int unsigned plen_w);
    return data_w + VLD_BIT + plen_w;
  endfunction

  // zero fill standing in for {wr_data, wr_en, bytes_inc} on cpu/fwd words
  function automatic int unsigned rd_pad_w(input int unsigned data_w, input int unsigned inc_w);
    return data_w + ENABLE_BIT + inc_w;
  endfunction

endpackage

// File: rtl/buffer_xbar_if.sv
// Ownership-map handshake between the buffer-allocation controller and the crossbar.
interface buffer_xbar_if #(
  parameter int unsigned SEL_WIDTH = 2
);
  logic                 sel_vld;
  logic                 sel_rdy;
  logic                 sel_ack;
  logic                 sel_err;
  logic [SEL_WIDTH-1:0] sn_sel_in;
  logic [SEL_WIDTH-1:0] cpu_sel_in;
  logic [SEL_WIDTH-1:0] fwd_sel_in;
  logic [SEL_WIDTH-1:0] sn_sel;
  logic [SEL_WIDTH-1:0] cpu_sel;
  logic [SEL_WIDTH-1:0] fwd_sel;

  modport master (
    output sel_vld, sn_sel_in, cpu_sel_in, fwd_sel_in,
    input  sel_rdy, sel_ack, sel_err, sn_sel, cpu_sel, fwd_sel
  );

  modport slave (
    input  sel_vld, sn_sel_in, cpu_sel_in, fwd_sel_in,
    output sel_rdy, sel_ack, sel_err, sn_sel, cpu_sel, fwd_sel
  );
endinterface

// File: rtl/buffer_xbar_rd_tracker.sv
// Outstanding-read window for one read agent: busy while any read of the last DEPTH cycles may still return.
module xbar_rd_tracker #(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rd_en,
  output logic busy
);
  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[DEPTH-2:0], rd_en};
  end

  assign busy = |sr;
endmodule

// File: rtl/buffer_xbar.sv
// Registered crossbar between snooper/CPU/forwarder and NUM_BUFS packet buffers,
// with handshaked, legality-checked ownership maps that never move a buffer under a pending read.
module buffer_xbar
  import bpf_xbar_pkg::*;
#(
  parameter int unsigned NUM_BUFS   = 3,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned INC_WIDTH  = 8,
  parameter int unsigned PLEN_WIDTH = 32,
  parameter int unsigned BUF_RD_LAT = 1,
  parameter int unsigned SEL_WIDTH  = $clog2(NUM_BUFS + 1)
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic [ADDR_WIDTH+DATA_WIDTH+INC_WIDTH:0]             from_sn,
  input  logic [ADDR_WIDTH+1:0]                                from_cpu,
  input  logic [ADDR_WIDTH+1:0]                                from_fwd,
  output logic [DATA_WIDTH+PLEN_WIDTH:0]                       to_cpu,
  output logic [DATA_WIDTH+PLEN_WIDTH:0]                       to_fwd,
  output logic [NUM_BUFS*(ADDR_WIDTH+DATA_WIDTH+INC_WIDTH+3)-1:0] to_buf,
  input  logic [NUM_BUFS*(DATA_WIDTH+PLEN_WIDTH+1)-1:0]        from_buf,
  buffer_xbar_if.slave                                         sel_bus
);
  localparam int unsigned BIN_W      = bin_w(ADDR_WIDTH, DATA_WIDTH, INC_WIDTH);
  localparam int unsigned BOUT_W     = bout_w(DATA_WIDTH, PLEN_WIDTH);
  localparam int unsigned RD_PAD_W   = rd_pad_w(DATA_WIDTH, INC_WIDTH);
  localparam int unsigned NUM_AGENTS = 3;
  localparam logic [SEL_WIDTH-1:0] MAX_SEL = SEL_WIDTH'(NUM_BUFS);

  logic [SEL_WIDTH-1:0] sn_sel_q, cpu_sel_q, fwd_sel_q;
  logic [SEL_WIDTH-1:0] req [NUM_AGENTS];
  logic                 legal, rdy, ack_q, err_q;
  logic                 cpu_rd, fwd_rd, cpu_busy, fwd_busy;
  logic [BIN_W-1:0]     sn_word, cpu_word, fwd_word;
  logic [BOUT_W-1:0]    cpu_ret, fwd_ret, to_cpu_q, to_fwd_q;

  assign sn_word  = {from_sn, {CTRL_PAD_W{1'b0}}};
  assign cpu_word = {from_cpu[ADDR_WIDTH+1 -: ADDR_WIDTH], {RD_PAD_W{1'b0}}, from_cpu[CTRL_PAD_W-1:0]};
  assign fwd_word = {from_fwd[ADDR_WIDTH+1 -: ADDR_WIDTH], {RD_PAD_W{1'b0}}, from_fwd[CTRL_PAD_W-1:0]};

  // a read only reaches a buffer (and so only needs tracking) when the agent owns one
  assign cpu_rd = from_cpu[0] & (cpu_sel_q != '0);
  assign fwd_rd = from_fwd[0] & (fwd_sel_q != '0);

  xbar_rd_tracker #(.DEPTH(BUF_RD_LAT + 2)) u_cpu_trk (
    .clk(clk), .rst_n(rst_n), .rd_en(cpu_rd), .busy(cpu_busy)
  );
  xbar_rd_tracker #(.DEPTH(BUF_RD_LAT + 2)) u_fwd_trk (
    .clk(clk), .rst_n(rst_n), .rd_en(fwd_rd), .busy(fwd_busy)
  );

  assign rdy = rst_n & ~cpu_busy & ~fwd_busy & ~from_cpu[0] & ~from_fwd[0];

  assign req[0] = sel_bus.sn_sel_in;
  assign req[1] = sel_bus.cpu_sel_in;
  assign req[2] = sel_bus.fwd_sel_in;

  always_comb begin
    legal = 1'b1;
    for (int unsigned i = 0; i < NUM_AGENTS; i++) begin
      if (req[i] > MAX_SEL) legal = 1'b0;
      for (int unsigned j = i + 1; j < NUM_AGENTS; j++) begin
        if (req[i] != '0 && req[i] == req[j]) legal = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sn_sel_q  <= '0;
      cpu_sel_q <= '0;
      fwd_sel_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (sel_bus.sel_vld && rdy) begin
        if (legal) begin
          sn_sel_q  <= req[0];
          cpu_sel_q <= req[1];
          fwd_sel_q <= req[2];
          ack_q     <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  // legal maps give each buffer at most one owner, so OR-ing the candidates is a one-hot mux
  for (genvar k = 0; k < NUM_BUFS; k++) begin : g_buf
    localparam logic [SEL_WIDTH-1:0] ID = SEL_WIDTH'(k + 1);
    logic [BIN_W-1:0] word;
    logic [BIN_W-1:0] q;

    always_comb begin
      word = '0;
      if (sn_sel_q  == ID) word = word | sn_word;
      if (cpu_sel_q == ID) word = word | cpu_word;
      if (fwd_sel_q == ID) word = word | fwd_word;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) q <= '0;
      else        q <= word;
    end

    assign to_buf[k*BIN_W +: BIN_W] = q;
  end

  always_comb begin
    cpu_ret = '0;
    fwd_ret = '0;
    for (int unsigned k = 0; k < NUM_BUFS; k++) begin
      if (cpu_sel_q == SEL_WIDTH'(k + 1)) cpu_ret = from_buf[k*BOUT_W +: BOUT_W];
      if (fwd_sel_q == SEL_WIDTH'(k + 1)) fwd_ret = from_buf[k*BOUT_W +: BOUT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cpu_q <= '0;
      to_fwd_q <= '0;
    end else begin
      to_cpu_q <= cpu_ret;
      to_fwd_q <= fwd_ret;
    end
  end

  assign to_cpu          = to_cpu_q;
  assign to_fwd          = to_fwd_q;
  assign sel_bus.sel_rdy = rdy;
  assign sel_bus.sel_ack = ack_q;
  assign sel_bus.sel_err = err_q;
  assign sel_bus.sn_sel  = sn_sel_q;
  assign sel_bus.cpu_sel = cpu_sel_q;
  assign sel_bus.fwd_sel = fwd_sel_q;
endmodule

// File: tb/tb_buffer_xbar.sv
// Bench for buffer_xbar: directed scenarios followed by random traffic, compared every cycle
// against a transaction-level model of routing, ownership maps and the read-drain rule.
module tb_buffer_xbar;
  localparam int unsigned N    = 3;
  localparam int unsigned AW   = 10;
  localparam int unsigned DW   = 64;
  localparam int unsigned IW   = 8;
  localparam int unsigned PW   = 32;
  localparam int unsigned LAT  = 1;
  localparam int unsigned SW   = 3;
  localparam int unsigned BIN  = AW + DW + IW + 3;
  localparam int unsigned BOUT = DW + PW + 1;
  localparam int unsigned D    = LAT + 2;
  localparam int unsigned CW   = N * BIN;

  logic            clk;
  logic            rst_n;
  logic [AW-1:0]   sn_addr, cpu_addr, fwd_addr;
  logic [DW-1:0]   sn_data;
  logic [IW-1:0]   sn_inc;
  logic            sn_wr, cpu_rst, cpu_rd, fwd_rst, fwd_rd;
  logic [AW+DW+IW:0] from_sn;
  logic [AW+1:0]   from_cpu, from_fwd;
  logic [BOUT-1:0] to_cpu, to_fwd;
  logic [N*BIN-1:0]  to_buf;
  logic [N*BOUT-1:0] from_buf;

  assign from_sn  = {sn_addr, sn_data, sn_wr, sn_inc};
  assign from_cpu = {cpu_addr, cpu_rst, cpu_rd};
  assign from_fwd = {fwd_addr, fwd_rst, fwd_rd};

  buffer_xbar_if #(.SEL_WIDTH(SW)) sel_bus ();

  buffer_xbar #(
    .NUM_BUFS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INC_WIDTH(IW),
    .PLEN_WIDTH(PW), .BUF_RD_LAT(LAT), .SEL_WIDTH(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .from_sn(from_sn), .from_cpu(from_cpu), .from_fwd(from_fwd),
    .to_cpu(to_cpu), .to_fwd(to_fwd), .to_buf(to_buf), .from_buf(from_buf), .sel_bus(sel_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [PW-1:0] plen(input int k);
    return 32'hA000_0000 + PW'(k);
  endfunction

  // packet buffers: single-cycle read latency, write-through memory
  logic [DW-1:0] mem [N][1<<AW];
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (to_buf[k*BIN + IW + 2])
        mem[k][to_buf[k*BIN + BIN - AW +: AW]] <= to_buf[k*BIN + IW + 3 +: DW];
      from_buf[k*BOUT +: BOUT] <= {(to_buf[k*BIN] ? mem[k][to_buf[k*BIN + BIN - AW +: AW]] : {DW{1'b0}}),
                                   to_buf[k*BIN], plen(k)};
    end
  end

  int checks = 0;
  int failures = 0;
  int map_m [3];
  int req_m [3];
  int cyc = 0;
  int last_rd = -100;
  bit last_xfer;

  task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit legal_map(input int s0, input int s1, input int s2);
    int cnt [N+1];
    int s [3];
    s = '{s0, s1, s2};
    foreach (cnt[b]) cnt[b] = 0;
    foreach (s[i]) begin
      if (s[i] > int'(N)) return 1'b0;
      if (s[i] != 0) cnt[s[i]]++;
    end
    foreach (cnt[b]) if (b != 0 && cnt[b] > 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic set_req(input int a, input int b, input int c);
    req_m = '{a, b, c};
    sel_bus.sn_sel_in  = SW'(a);
    sel_bus.cpu_sel_in = SW'(b);
    sel_bus.fwd_sel_in = SW'(c);
  endtask

  task automatic idle();
    sn_addr = '0; sn_data = '0; sn_wr = 1'b0; sn_inc = '0;
    cpu_addr = '0; cpu_rst = 1'b0; cpu_rd = 1'b0;
    fwd_addr = '0; fwd_rst = 1'b0; fwd_rd = 1'b0;
  endtask

  // one clock: predict from the map in force this cycle, then compare after the edge
  task automatic step();
    logic [N*BIN-1:0] eb;
    logic [BOUT-1:0]  ec, ef;
    logic             ea, ee, erdy;
    int               nm [3];
    last_xfer = 1'b0;
    #1;
    erdy = rst_n && (cyc - last_rd > int'(D)) && !cpu_rd && !fwd_rd;
    chk($sformatf("sel_rdy@%0d", cyc), CW'(sel_bus.sel_rdy), CW'(erdy));
    eb = '0; ec = '0; ef = '0; ea = 1'b0; ee = 1'b0;
    nm = map_m;
    if (rst_n) begin
      for (int k = 0; k < int'(N); k++) begin
        if (map_m[0] == k + 1) eb[k*BIN +: BIN] = {sn_addr, sn_data, sn_wr, sn_inc, 1'b0, 1'b0};
        if (map_m[1] == k + 1) eb[k*BIN +: BIN] = {cpu_addr, {DW{1'b0}}, 1'b0, {IW{1'b0}}, cpu_rst, cpu_rd};
        if (map_m[2] == k + 1) eb[k*BIN +: BIN] = {fwd_addr, {DW{1'b0}}, 1'b0, {IW{1'b0}}, fwd_rst, fwd_rd};
      end
      if (map_m[1] != 0) ec = from_buf[(map_m[1]-1)*BOUT +: BOUT];
      if (map_m[2] != 0) ef = from_buf[(map_m[2]-1)*BOUT +: BOUT];
      if (sel_bus.sel_vld && erdy) begin
        last_xfer = 1'b1;
        if (legal_map(req_m[0], req_m[1], req_m[2])) begin
          ea = 1'b1;
          nm = req_m;
        end else begin
          ee = 1'b1;
        end
      end
      if ((cpu_rd && map_m[1] != 0) || (fwd_rd && map_m[2] != 0)) last_rd = cyc;
    end else begin
      nm = '{0, 0, 0};
      last_rd = -100;
    end
    map_m = nm;
    @(posedge clk);
    #1;
    chk($sformatf("to_buf@%0d", cyc), CW'(to_buf), CW'(eb));
    chk($sformatf("to_cpu@%0d", cyc), CW'(to_cpu), CW'(ec));
    chk($sformatf("to_fwd@%0d", cyc), CW'(to_fwd), CW'(ef));
    chk($sformatf("sel_ack@%0d", cyc), CW'(sel_bus.sel_ack), CW'(ea));
    chk($sformatf("sel_err@%0d", cyc), CW'(sel_bus.sel_err), CW'(ee));
    chk($sformatf("map@%0d", cyc), CW'({sel_bus.sn_sel, sel_bus.cpu_sel, sel_bus.fwd_sel}),
        CW'({SW'(map_m[0]), SW'(map_m[1]), SW'(map_m[2])}));
    cyc++;
  endtask

  initial begin
    int n;
    for (int k = 0; k < int'(N); k++)
      for (int a = 0; a < (1 << AW); a++)
        mem[k][a] <= {$urandom, $urandom};
    mem[1][7] <= 64'h1234;
    map_m = '{0, 0, 0};
    rst_n = 1'b0;
    idle();
    sel_bus.sel_vld = 1'b0;
    set_req(0, 0, 0);
    step();
    step();
    rst_n = 1'b1;

    // first map
    set_req(1, 2, 3);
    sel_bus.sel_vld = 1'b1;
    step();
    sel_bus.sel_vld = 1'b0;
    step();

    // snooper write lands in buffer 0 only
    sn_addr = 10'd5; sn_data = 64'hDEADBEEF; sn_wr = 1'b1; sn_inc = 8'd4;
    step();
    chk("sn_write_slice0", CW'(to_buf[0 +: BIN]), CW'({10'd5, 64'hDEADBEEF, 1'b1, 8'd4, 2'b00}));
    chk("sn_write_others", CW'(to_buf[BIN +: 2*BIN]), '0);
    idle();
    step();

    // cpu read round trip through buffer 1
    cpu_addr = 10'd7; cpu_rd = 1'b1;
    step();
    idle();
    step();
    step();
    chk("cpu_read_return", CW'(to_cpu), CW'({64'h1234, 1'b1, plen(1)}));
    step();
    step();

    // map request behind an outstanding read stalls until the tracker drains
    cpu_addr = 10'd3; cpu_rd = 1'b1;
    step();
    idle();
    set_req(3, 1, 2);
    sel_bus.sel_vld = 1'b1;
    n = 0;
    while (!last_xfer && n < 10) begin
      step();
      n++;
    end
    sel_bus.sel_vld = 1'b0;
    chk("stall_len", CW'(n), CW'(D + 1));
    step();

    // illegal maps, then the identical map
    set_req(2, 2, 3); sel_bus.sel_vld = 1'b1; step();
    sel_bus.sel_vld = 1'b0; step();
    set_req(1, 2, 4); sel_bus.sel_vld = 1'b1; step();
    sel_bus.sel_vld = 1'b0; step();
    set_req(3, 1, 2); sel_bus.sel_vld = 1'b1; step();
    sel_bus.sel_vld = 1'b0; step();

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      sn_addr = AW'($urandom); sn_data = {$urandom, $urandom}; sn_wr = 1'($urandom);
      sn_inc = IW'($urandom);
      cpu_addr = AW'($urandom); cpu_rst = 1'($urandom); cpu_rd = ($urandom_range(0, 7) == 0);
      fwd_addr = AW'($urandom); fwd_rst = 1'($urandom); fwd_rd = ($urandom_range(0, 7) == 0);
      if (!sel_bus.sel_vld || last_xfer) begin
        if ($urandom_range(0, 2) == 0) begin
          set_req($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
          sel_bus.sel_vld = 1'b1;
        end else begin
          sel_bus.sel_vld = 1'b0;
        end
      end
      rst_n = ($urandom_range(0, 39) != 0);
      step();
    end

    // reset while a cpu read is in flight
    rst_n = 1'b1;
    sel_bus.sel_vld = 1'b0;
    idle();
    for (int i = 0; i < 5; i++) step();
    set_req(1, 2, 3); sel_bus.sel_vld = 1'b1; step();
    sel_bus.sel_vld = 1'b0;
    cpu_addr = 10'd7; cpu_rd = 1'b1;
    step();
    idle();
    rst_n = 1'b0;
    step();
    chk("reset_to_cpu_now", CW'(to_cpu), '0);
    rst_n = 1'b1;
    step();
    step();
    chk("reset_to_cpu_later", CW'(to_cpu), '0);
    chk("reset_map", CW'({sel_bus.sn_sel, sel_bus.cpu_sel, sel_bus.fwd_sel}), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
